gate_test_sequencer: RTL and testbench
======================================

Name: gate_test_sequencer

Overview:
- Self-checking stimulus controller for a 2-input logic gate datapath (e.g. and_gate).
- Drives the gate inputs A/B through all four input vectors, holds each vector for a configurable dwell, then compares the gate output against the AND truth table.
- Reports pass/fail, an error count and a per-vector fail mask for board LEDs.
- Sits between board start button/LEDs and the gate under test in the top level.

Parameters:
- DWELL_CYCLES, 4, clock cycles each vector is driven before sampling; legal range >= 2.
- ERR_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  run request, level-sampled each clk edge
- gate_a  output  1  drives gate input A
- gate_b  output  1  drives gate input B
- gate_f  input  1  gate output under test
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a pass completes
- pass  output  1  high when the last completed run had zero errors
- err_count  output  ERR_W  mismatches in the last run, saturating
- fail_mask  output  4  bit i set if vector i ({A,B}=i) mismatched
- vec_idx  output  2  current vector index

Behaviour:
- Reset: state IDLE; all outputs 0; dwell counter 0.
- rst mid-run aborts the run immediately. The next cycle is IDLE with everything cleared.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - busy=0.
  - If start=1 at an edge: clear err_count, fail_mask and pass; set vec_idx=0; go to DRIVE.
- DRIVE:
  - busy=1; {gate_a,gate_b}=vec_idx, registered outputs.
  - The dwell counter counts 0..DWELL_CYCLES-1.
  - On the edge ending the cycle where count==DWELL_CYCLES-1, sample gate_f and compare it with expected EXP[vec_idx].
  - On mismatch: set fail_mask[vec_idx]; err_count += 1, saturating at 2^ERR_W-1.
  - After the sample, the counter resets to 0. If vec_idx==3, go to DONE; otherwise vec_idx += 1.
- DONE:
  - done=1 for exactly one cycle; busy=1.
  - pass = (err_count==0 after the final sample); pass is registered on DONE entry.
  - Then go to IDLE; gate_a/gate_b return to 0.
- Latency: start accepted at edge 0 -> DRIVE cycles 1..4*DWELL_CYCLES -> done high in cycle 4*DWELL_CYCLES+1.
  - Default: done in cycle 17.
- start while busy (DRIVE or DONE) is ignored.
  - start held high through DONE triggers a new run from IDLE on the following edge.
- Results (pass, err_count, fail_mask) hold stable in IDLE until the next accepted start.
- vec_idx wraps 3->0 only in loop mode (see below).
- Any simultaneous mismatch and saturation leaves err_count at max and still sets the fail_mask bit.

Optional Feature:
- Macro GATE_SEQ_LOOP_EN.
- Defined:
  - At the end of vector 3, if start=1, vec_idx wraps to 0 and DRIVE continues.
  - done pulses for one cycle at each pass boundary, concurrent with the first DRIVE cycle of the next pass.
  - pass updates at each boundary.
  - err_count and fail_mask accumulate across passes, saturating; they are not cleared between passes.
  - When start=0 at the end of vector 3: go to DONE, then IDLE as normal.
- Undefined: single pass per accepted start; the start level after acceptance is ignored.

Decomposition:
- Package gate_seq_pkg holds:
  - state enum (IDLE, DRIVE, DONE);
  - NUM_VECTORS=4;
  - truth-table constant EXP=4'b1000, where bit i is the expected F for {A,B}=i.
- The truth table lives in the package so an OR/XOR variant only changes a constant.
- No sub-module. The dwell counter is inline; the gate under test is instantiated only at top level and in the bench.

Test Plan:
- Correct AND gate on gate_f, DWELL_CYCLES=4, start pulsed 1 cycle -> done high in cycle 17, pass=1, err_count=0, fail_mask=4'b0000.
- gate_f stuck at 1 -> fail_mask=4'b0111, err_count=3, pass=0; the results hold in IDLE for 10 further cycles.
- OR gate substituted (F=A|B) -> fail_mask=4'b0110, err_count=2, pass=0; check the gate_a/gate_b sequence 00,01,10,11, each held 4 cycles.
- Start re-pulsed in cycles 5 and 17 -> no restart; done only in cycle 17; a start in cycle 18 (IDLE) begins a new run with the results cleared.
- rst asserted in cycle 9 -> cycle 10: busy=0, gate_a=gate_b=0, err_count=0, fail_mask=0; a subsequent start completes a full pass normally.
- GATE_SEQ_LOOP_EN, ERR_W=2, gate_f stuck at 0, start held for 4 passes:
  - expect err_count 1,2,3,3 at successive done pulses and fail_mask=4'b1000;
  - drop start -> DONE then IDLE.

Source files
------------

// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate test sequencer.
// The expected truth table lives here so an OR/XOR variant only edits EXP.
package gate_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 4;

  // Bit i is the expected gate output for {A,B} = i (AND gate).
  localparam logic [NUM_VECTORS-1:0] EXP = 4'b1000;

  function automatic logic exp_bit(input logic [1:0] vec);
    return EXP[vec];
  endfunction

endpackage

// File: rtl/gate_test_sequencer.sv
// Walks a 2-input gate through all four input vectors, checks its output
// against gate_seq_pkg::EXP and reports pass/err_count/fail_mask.
// Optional macro GATE_SEQ_LOOP_EN: keep looping passes while start is held.
module gate_test_sequencer
  import gate_seq_pkg::*;
#(
  parameter int DWELL_CYCLES = 4,
  parameter int ERR_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             gate_a,
  output logic             gate_b,
  input  logic             gate_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_mask,
  output logic [1:0]       vec_idx
);

  localparam int CNT_W = $clog2(DWELL_CYCLES);

  state_t                          r_state, w_nxt_state;
  logic [CNT_W-1:0]                r_cnt, w_nxt_cnt;
  logic [1:0]                      r_vec, w_nxt_vec;
  logic [ERR_W-1:0]                r_err, w_nxt_err;
  logic [NUM_VECTORS-1:0]          r_mask, w_nxt_mask;
  logic                            r_pass, w_nxt_pass;
  logic                            r_done, w_nxt_done;
  logic [1:0]                      r_ab, w_nxt_ab;

  logic                            w_last;
  logic                            w_mis;
  logic [ERR_W-1:0]                w_err_s;

  assign w_last  = (r_cnt == CNT_W'(DWELL_CYCLES - 1));
  assign w_mis   = (gate_f != exp_bit(r_vec));
  // Error count after this cycle's sample; saturates at all-ones.
  assign w_err_s = (w_mis && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_vec   = r_vec;
    w_nxt_err   = r_err;
    w_nxt_mask  = r_mask;
    w_nxt_pass  = r_pass;
    w_nxt_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_nxt_state = DRIVE;
          w_nxt_cnt   = '0;
          w_nxt_vec   = '0;
          w_nxt_err   = '0;
          w_nxt_mask  = '0;
          w_nxt_pass  = 1'b0;
        end
      end
      DRIVE: begin
        w_nxt_cnt = r_cnt + CNT_W'(1);
        if (w_last) begin
          w_nxt_cnt = '0;
          w_nxt_err = w_err_s;
          if (w_mis) w_nxt_mask[r_vec] = 1'b1;
          if (r_vec == 2'(NUM_VECTORS - 1)) begin
            w_nxt_done = 1'b1;
            w_nxt_pass = (w_err_s == '0);
`ifdef GATE_SEQ_LOOP_EN
            if (start) w_nxt_vec = '0;
            else       w_nxt_state = DONE;
`else
            w_nxt_state = DONE;
`endif
          end else begin
            w_nxt_vec = r_vec + 2'd1;
          end
        end
      end
      DONE: begin
        w_nxt_state = IDLE;
      end
      default: begin
        w_nxt_state = IDLE;
      end
    endcase
    // Gate inputs are registered from the next-state view so they line up with DRIVE.
    w_nxt_ab = (w_nxt_state == DRIVE) ? w_nxt_vec : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_vec   <= '0;
      r_err   <= '0;
      r_mask  <= '0;
      r_pass  <= 1'b0;
      r_done  <= 1'b0;
      r_ab    <= 2'b00;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_vec   <= w_nxt_vec;
      r_err   <= w_nxt_err;
      r_mask  <= w_nxt_mask;
      r_pass  <= w_nxt_pass;
      r_done  <= w_nxt_done;
      r_ab    <= w_nxt_ab;
    end
  end

  assign gate_a    = r_ab[1];
  assign gate_b    = r_ab[0];
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_mask = r_mask;
  assign vec_idx   = r_vec;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: table of gate models with expected
// results, plus hand sequences for restart, mid-run reset and loop mode.
module tb_gate_test_sequencer;

  localparam int DW = 4;
`ifdef GATE_SEQ_LOOP_EN
  localparam int EW = 2;
`else
  localparam int EW = 4;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          gate_f;
  logic          gate_a, gate_b, busy, done, pass;
  logic [EW-1:0] err_count;
  logic [3:0]    fail_mask;
  logic [1:0]    vec_idx;

  int mode = 0;
  int nvec = 0;
  int nerr = 0;

  gate_test_sequencer #(.DWELL_CYCLES(DW), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .gate_a(gate_a), .gate_b(gate_b), .gate_f(gate_f),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_mask(fail_mask), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;

  // Gate under test: 0 AND, 1 stuck-1, 2 OR, 3 stuck-0, 4 XOR
  always_comb begin
    case (mode)
      0:       gate_f = gate_a & gate_b;
      1:       gate_f = 1'b1;
      2:       gate_f = gate_a | gate_b;
      3:       gate_f = 1'b0;
      default: gate_f = gate_a ^ gate_b;
    endcase
  end

  typedef struct {
    int         mode;
    logic       exp_pass;
    logic [3:0] exp_err;
    logic [3:0] exp_mask;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Current cycle counts as 1; returns the cycle number where done is seen, -1 on timeout.
  task automatic wait_done(input logic chk_ab, output int dc);
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      if (chk_ab && c <= 4 * DW) begin
        chk("drive_ab", {gate_a, gate_b}, (c - 1) / DW);
        chk("drive_busy", busy, 1);
      end
      if (done) begin
        dc = c;
        break;
      end
      tick();
    end
  endtask

  // Pulse start for one cycle (cycle 0) and wait for done.
  task automatic run_pass(output int dc);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b1, dc);
    chk("done_cycle", dc, 4 * DW + 1);
  endtask

  vec_t tbl[5];
  int   dc;
  int   ndone;

  initial begin
    tbl[0] = '{0, 1'b1, 4'd0, 4'b0000};
    tbl[1] = '{1, 1'b0, 4'd3, 4'b0111};
    tbl[2] = '{2, 1'b0, 4'd2, 4'b0110};
    tbl[3] = '{3, 1'b0, 4'd1, 4'b1000};
    tbl[4] = '{4, 1'b0, 4'd3, 4'b1110};

    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_mask", fail_mask, 0);
    chk("rst_vec", vec_idx, 0);
    chk("rst_ab", {gate_a, gate_b}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      mode = tbl[i].mode;
      run_pass(dc);
      chk("pass", pass, tbl[i].exp_pass);
      chk("err_count", err_count, tbl[i].exp_err);
      chk("fail_mask", fail_mask, tbl[i].exp_mask);
      chk("done_busy", busy, 1);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ab", {gate_a, gate_b}, 0);
      repeat (10) tick();
      chk("hold_pass", pass, tbl[i].exp_pass);
      chk("hold_err", err_count, tbl[i].exp_err);
      chk("hold_mask", fail_mask, tbl[i].exp_mask);
    end

    // Start re-pulsed during DRIVE (cycle 5) and DONE (cycle 17) is ignored;
    // start in cycle 18 (IDLE) begins a fresh run.
    mode  = 1;
    start = 1'b1;
    tick();
    ndone = 0;
    for (int c = 1; c <= 18; c++) begin
      start = (c == 5 || c == 17 || c == 18);
      if (done) ndone++;
      if (c == 17) chk("repulse_done17", done, 1);
      if (c == 18) chk("repulse_idle18", busy, 0);
      tick();
    end
    start = 1'b0;
    chk("repulse_ndone", ndone, 1);
    chk("restart_busy", busy, 1);
    chk("restart_err", err_count, 0);
    chk("restart_mask", fail_mask, 0);
    chk("restart_pass", pass, 0);
    mode = 0;
    wait_done(1'b0, dc);
    chk("restart_done_cycle", dc, 4 * DW + 1);
    chk("restart_result", pass, 1);
    tick();

    // Synchronous reset in cycle 9 aborts the run.
    mode  = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("pre_rst_err", err_count, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ab", {gate_a, gate_b}, 0);
    chk("abort_err", err_count, 0);
    chk("abort_mask", fail_mask, 0);
    chk("abort_vec", vec_idx, 0);
    chk("abort_done", done, 0);
    mode = 0;
    run_pass(dc);
    chk("after_abort_pass", pass, 1);
    chk("after_abort_err", err_count, 0);
    tick();

`ifdef GATE_SEQ_LOOP_EN
    // Loop mode, stuck-0 gate: start held for three boundaries, dropped in cycle 49.
    begin
      int cyc[4];
      int errs[4];
      int k;
      mode  = 3;
      k     = 0;
      start = 1'b1;
      tick();
      for (int c = 1; c <= 65; c++) begin
        if (c == 49) start = 1'b0;
        if (done) begin
          if (k < 4) begin
            cyc[k]  = c;
            errs[k] = int'(err_count);
          end
          k++;
          chk("loop_pass", pass, 0);
        end
        if (c == 17) begin
          chk("loop_busy17", busy, 1);
          chk("loop_ab17", {gate_a, gate_b}, 0);
        end
        tick();
      end
      chk("loop_ndone", k, 4);
      if (k >= 4) begin
        chk("loop_cyc0", cyc[0], 17);
        chk("loop_cyc1", cyc[1], 33);
        chk("loop_cyc2", cyc[2], 49);
        chk("loop_cyc3", cyc[3], 65);
        chk("loop_err0", errs[0], 1);
        chk("loop_err1", errs[1], 2);
        chk("loop_err2", errs[2], 3);
        chk("loop_err3", errs[3], 3);
      end
      chk("loop_mask", fail_mask, 4'b1000);
      chk("loop_idle", busy, 0);
      chk("loop_ab_idle", {gate_a, gate_b}, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
